// File: rtl/switch_bounce_emulator_if.sv
// rtl/switch_bounce_emulator_if.sv - switch-side signal bundle between stimulus driver and bounce emulator
interface switch_bounce_emulator_if;
  logic en_i;
  logic clean_i;
  logic tick_i;
  logic sw_o;
  logic busy_o;
  logic done_o;

  modport master (output en_i, clean_i, tick_i, input sw_o, busy_o, done_o);
  modport slave  (input en_i, clean_i, tick_i, output sw_o, busy_o, done_o);
endinterface

// File: rtl/switch_bounce_emulator.sv
// rtl/switch_bounce_emulator.sv - bouncy switch waveform generator from a clean level (optional SWB_SEED_PORT_EN adds runtime LFSR seeding)
module switch_bounce_emulator #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          BNC_W  = 3,
  parameter int          HOLD_W = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
`ifdef SWB_SEED_PORT_EN
  input  logic [15:0]              seed_i,
  input  logic                     seed_load_i,
`endif
  switch_bounce_emulator_if.slave  sw_if
);

  localparam int CW = BNC_W + 1;
  localparam int HW = HOLD_W + 1;
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONTACT = 2'd1;
  localparam logic [1:0] ST_GLITCH  = 2'd2;

  logic [15:0]   lfsr_q;
  logic          lfsr_fb;
  logic [1:0]    state_q, state_d;
  logic          tgt_q, tgt_d;
  logic          sw_q, sw_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [CW-1:0] n_val;
  logic [HW-1:0] h_val;

  // Taps for x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Bounce count and phase hold are both biased by one so neither can be zero
  assign n_val = {1'b0, lfsr_q[BNC_W-1:0]} + CW'(1);
  assign h_val = {1'b0, lfsr_q[HOLD_W+7:8]} + HW'(1);

  // Free-running LFSR, frozen while bypassed; a seed load overrides the shift
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= SEED_NZ;
    end
`ifdef SWB_SEED_PORT_EN
    else if (seed_load_i) begin
      lfsr_q <= (seed_i == 16'h0000) ? 16'h0001 : seed_i;
    end
`endif
    else if (sw_if.en_i) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Next-state logic: bypass beats restart, restart beats hold expiry
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    sw_d    = sw_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (!sw_if.en_i) begin
      state_d = ST_IDLE;
      sw_d    = sw_if.clean_i;
      tgt_d   = sw_if.clean_i;
    end else if (sw_if.clean_i != tgt_q) begin
      tgt_d   = sw_if.clean_i;
      sw_d    = sw_if.clean_i;
      cnt_d   = n_val;
      hold_d  = h_val;
      state_d = ST_CONTACT;
    end else if (sw_if.tick_i) begin
      case (state_q)
        ST_CONTACT: begin
          if (hold_q == HW'(1)) begin
            if (cnt_q != '0) begin
              sw_d    = ~tgt_q;
              hold_d  = h_val;
              state_d = ST_GLITCH;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        ST_GLITCH: begin
          if (hold_q == HW'(1)) begin
            sw_d    = tgt_q;
            cnt_d   = cnt_q - CW'(1);
            hold_d  = h_val;
            state_d = ST_CONTACT;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      tgt_q   <= 1'b0;
      sw_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  assign sw_if.sw_o   = sw_q;
  assign sw_if.busy_o = (state_q != ST_IDLE);
  assign sw_if.done_o = done_q;

endmodule
